row_packer: RTL

- Upstream feeder for the 128-wide 3-tap row convolution stage.
- Accepts a raster pixel stream one 8-bit pixel per cycle over a valid/ready handshake.
- Assembles each complete row into a padded (ROW_W+2)-pixel vector and presents it to the convolution stage with its own valid/ready handshake.
- Holds the 24-bit kernel weight in a register that updates only at row boundaries, so a row is never convolved with mixed weights.

---
 rtl/row_packer_pkg.sv | 23 ++
 rtl/row_pad_assemble.sv | 32 +++
 rtl/row_packer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/row_packer_pkg.sv
// Shared definitions for the row packer and the 3-tap row convolution stage.
// Row geometry, tap count, padding encodings and the packer FSM states.
package row_packer_pkg;

    localparam int unsigned ROW_W = 128;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned TAPS  = 3;
    localparam int unsigned PAD_W = (ROW_W + 2) * PIX_W;

    localparam logic [0:0] PAD_ZERO = 1'b0;
    localparam logic [0:0] PAD_REPL = 1'b1;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Even parity over one pixel, for downstream integrity checkers.
    function automatic logic pix_parity(input logic [PIX_W-1:0] pix);
        return ^pix;
    endfunction

endpackage

// File: rtl/row_pad_assemble.sv
// Combinational edge padding: wraps a ROW_W-pixel buffer with one pad pixel on
// each side, either zeros or a copy of the adjacent edge pixel.
module row_pad_assemble
    import row_packer_pkg::*;
#(
    parameter int unsigned ROW_W    = row_packer_pkg::ROW_W,
    parameter int unsigned PIX_W    = row_packer_pkg::PIX_W,
    parameter logic [0:0]  PAD_MODE = PAD_ZERO
) (
    input  logic [ROW_W*PIX_W-1:0]     pix_buf,
    output logic [(ROW_W+2)*PIX_W-1:0] row_vec
);

    logic [PIX_W-1:0] pad_lo_s;
    logic [PIX_W-1:0] pad_hi_s;

    // Select the pad pixels for the configured edge policy.
    always_comb begin
        pad_lo_s = {PIX_W{1'b0}};
        pad_hi_s = {PIX_W{1'b0}};
        if (PAD_MODE == PAD_REPL) begin
            pad_lo_s = pix_buf[PIX_W-1:0];
            pad_hi_s = pix_buf[(ROW_W-1)*PIX_W +: PIX_W];
        end else begin
            pad_lo_s = {PIX_W{1'b0}};
            pad_hi_s = {PIX_W{1'b0}};
        end
    end

    assign row_vec = {pad_hi_s, pix_buf, pad_lo_s};

endmodule

// File: rtl/row_packer.sv
// Collects a raster pixel stream into padded rows for the row convolution
// stage, binding the staged kernel weight to each row as it is presented.
module row_packer
    import row_packer_pkg::*;
#(
    parameter int unsigned ROW_W    = row_packer_pkg::ROW_W,
    parameter int unsigned PIX_W    = row_packer_pkg::PIX_W,
    parameter logic [0:0]  PAD_MODE = PAD_ZERO
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIX_W-1:0]           pix_in,
    input  logic                       pix_valid,
    input  logic                       pix_sol,
    output logic                       pix_ready,
    input  logic [TAPS*PIX_W-1:0]      weight_in,
    input  logic                       weight_load,
    output logic [(ROW_W+2)*PIX_W-1:0] row_data,
    output logic [TAPS*PIX_W-1:0]      weight,
    output logic                       row_valid,
    input  logic                       row_ready,
    output logic                       err_short,
    output logic [15:0]                row_count
);

    localparam int unsigned CNT_W = $clog2(ROW_W + 1);
    localparam int unsigned BUF_W = ROW_W * PIX_W;
    localparam int unsigned VEC_W = (ROW_W + 2) * PIX_W;
    localparam int unsigned WGT_W = TAPS * PIX_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [VEC_W-1:0]   row_data_q, row_data_d;
    logic [WGT_W-1:0]   weight_q, weight_d;
    logic [WGT_W-1:0]   wstg_q, wstg_d;
    logic               row_valid_q, row_valid_d;
    logic               err_short_q, err_short_d;
    logic [15:0]        row_count_q, row_count_d;
    logic               pix_ready_q, pix_ready_d;

    logic [VEC_W-1:0]   row_vec_s;
    logic [CNT_W-1:0]   wr_idx_s;
    logic               pix_acc_s;
    logic               out_acc_s;
    logic               slot_free_s;
    logic               restart_s;
    logic               last_s;
    logic               xfer_s;

    assign pix_acc_s   = pix_valid && pix_ready_q;
    assign out_acc_s   = row_valid_q && row_ready;
    assign slot_free_s = !row_valid_q || row_ready;
    // A start-of-line mid-row restarts the fill at pixel 0.
    assign restart_s   = pix_acc_s && pix_sol && (cnt_q != {CNT_W{1'b0}});
    assign wr_idx_s    = restart_s ? {CNT_W{1'b0}} : cnt_q;
    assign last_s      = pix_acc_s && (wr_idx_s == LAST_IDX);

    // Write accepted pixels into the fill buffer and advance the fill count.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (pix_acc_s) begin
            buf_d[int'(wr_idx_s) * PIX_W +: PIX_W] = pix_in;
            if (last_s) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = wr_idx_s + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // The buffer feeding the pad stage already contains this cycle's pixel.
    row_pad_assemble #(
        .ROW_W    (ROW_W),
        .PIX_W    (PIX_W),
        .PAD_MODE (PAD_MODE)
    ) u_pad (
        .pix_buf (buf_d),
        .row_vec (row_vec_s)
    );

    // Fill/hold sequencing and output slot management.
    always_comb begin
        state_d     = state_q;
        xfer_s      = 1'b0;
        row_data_d  = row_data_q;
        weight_d    = weight_q;
        row_valid_d = row_valid_q;
        case (state_q)
            FILL: begin
                if (last_s) begin
                    if (slot_free_s) begin
                        xfer_s = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (out_acc_s) begin
                    xfer_s  = 1'b1;
                    state_d = FILL;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        pix_ready_d = (state_d == FILL);

        // The staged weight is sampled before any same-cycle load lands.
        if (xfer_s) begin
            row_data_d  = row_vec_s;
            weight_d    = wstg_q;
            row_valid_d = 1'b1;
        end else if (out_acc_s) begin
            row_valid_d = 1'b0;
        end else begin
            row_valid_d = row_valid_q;
        end
    end

    // Side-band bookkeeping: staged weight, short-row flag, delivered rows.
    always_comb begin
        err_short_d = restart_s;
        if (weight_load) begin
            wstg_d = weight_in;
        end else begin
            wstg_d = wstg_q;
        end
        if (out_acc_s) begin
            row_count_d = row_count_q + 16'd1;
        end else begin
            row_count_d = row_count_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            cnt_q       <= {CNT_W{1'b0}};
            buf_q       <= {BUF_W{1'b0}};
            row_data_q  <= {VEC_W{1'b0}};
            weight_q    <= {WGT_W{1'b0}};
            wstg_q      <= {WGT_W{1'b0}};
            row_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            row_count_q <= 16'd0;
            pix_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            row_data_q  <= row_data_d;
            weight_q    <= weight_d;
            wstg_q      <= wstg_d;
            row_valid_q <= row_valid_d;
            err_short_q <= err_short_d;
            row_count_q <= row_count_d;
            pix_ready_q <= pix_ready_d;
        end
    end

    assign pix_ready = pix_ready_q;
    assign row_data  = row_data_q;
    assign weight    = weight_q;
    assign row_valid = row_valid_q;
    assign err_short = err_short_q;
    assign row_count = row_count_q;

endmodule
